// File: rtl/dt_map_streamer.sv
// dt_map_streamer: scans the distance-transform result RAM in
// row-major order and streams every pixel over valid/ready.
//
// Ports:
//   clk, reset       clock; asynchronous active-low reset
//   start            begin a scan (honoured in IDLE/DONE only)
//   res_rd/res_addr  result RAM read strobe and address
//   res_di           result RAM data, valid the cycle after issue
//   out_valid/ready  output handshake
//   out_data/x/y     pixel value and coordinates
//   out_last         final pixel of the image
//   busy, scan_done  scan in progress / scan finished
//   max_val/addr     running maximum and first address holding it
// Optional (DT_STREAM_THRESH_EN):
//   thr              threshold sampled as each pixel enters the FIFO
//   out_bin          out_data >= thr for the head pixel
//   bin_count        transferred pixels with out_bin set
module dt_map_streamer #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     res_rd,
    output logic [ADDR_W-1:0]        res_addr,
    input  logic [DATA_W-1:0]        res_di,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(IMG_W)-1:0] out_x,
    output logic [$clog2(IMG_H)-1:0] out_y,
    output logic                     out_last,
`ifdef DT_STREAM_THRESH_EN
    input  logic [DATA_W-1:0]        thr,
    output logic                     out_bin,
    output logic [ADDR_W:0]          bin_count,
`endif
    output logic                     busy,
    output logic                     scan_done,
    output logic [DATA_W-1:0]        max_val,
    output logic [ADDR_W-1:0]        max_addr
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    localparam logic [XW-1:0] X_MAX =
        XW'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] A_LAST =
        ADDR_W'(IMG_W * IMG_H - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [XW-1:0]     x;
        logic [YW-1:0]     y;
        logic              last;
`ifdef DT_STREAM_THRESH_EN
        logic              bin;
`endif
    } ent_t;

    state_t state, state_n;

    // next read coordinates
    logic [ADDR_W-1:0] rd_cnt;
    logic [XW-1:0]     rd_x;
    logic [YW-1:0]     rd_y;

    // coordinates of the read currently in flight
    logic [XW-1:0]     pend_x;
    logic [YW-1:0]     pend_y;
    logic              pend_last;

    ent_t              fifo_q [2];
    logic              wp, rp;
    logic [1:0]        cnt;

    ent_t              head, ent_in;
    logic              push, pop;
    logic              start_go, scan_iss, issue;
    logic              credit_ok;
    logic [2:0]        occ;
    logic [ADDR_W-1:0] cur_a, head_addr;
    logic [XW-1:0]     cur_x;
    logic [YW-1:0]     cur_y;
    logic              cur_last;

    assign head = fifo_q[rp];
    assign out_valid = (cnt != 2'd0);
    assign pop  = out_valid && out_ready;
    // res_rd doubles as the in-flight flag: data lands this cycle
    assign push = res_rd;

    // credit counts the slot freed by this cycle's pop so a
    // ready consumer sees one pixel per cycle
    assign occ = {1'b0, cnt}
               + {2'b00, res_rd}
               - {2'b00, pop};
    assign credit_ok = (occ < 3'd2);

    // entry into SCAN always issues address 0
    assign cur_a    = (state == SCAN) ? rd_cnt : '0;
    assign cur_x    = (state == SCAN) ? rd_x : '0;
    assign cur_y    = (state == SCAN) ? rd_y : '0;
    assign cur_last = (cur_a == A_LAST);

    assign issue = start_go || scan_iss;

    assign head_addr = ADDR_W'(head.y) * ADDR_W'(IMG_W)
                     + ADDR_W'(head.x);

    always_comb begin
        ent_in      = '0;
        ent_in.data = res_di;
        ent_in.x    = pend_x;
        ent_in.y    = pend_y;
        ent_in.last = pend_last;
`ifdef DT_STREAM_THRESH_EN
        ent_in.bin  = (res_di >= thr);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        start_go = 1'b0;
        scan_iss = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    start_go = 1'b1;
                    state_n  = SCAN;
                end
            end
            SCAN: begin
                if (credit_ok) begin
                    scan_iss = 1'b1;
                    if (cur_last) state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head.last) state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_rd    <= 1'b0;
            res_addr  <= '0;
            rd_cnt    <= '0;
            rd_x      <= '0;
            rd_y      <= '0;
            pend_x    <= '0;
            pend_y    <= '0;
            pend_last <= 1'b0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wp        <= 1'b0;
            rp        <= 1'b0;
            cnt       <= 2'd0;
            max_val   <= '0;
            max_addr  <= '0;
        end else begin
            res_rd <= issue;
            if (issue) begin
                res_addr  <= cur_a;
                pend_x    <= cur_x;
                pend_y    <= cur_y;
                pend_last <= cur_last;
                // counters park on the final pixel
                if (!cur_last) begin
                    rd_cnt <= cur_a + ADDR_W'(1);
                    if (cur_x == X_MAX) begin
                        rd_x <= '0;
                        rd_y <= cur_y + YW'(1);
                    end else begin
                        rd_x <= cur_x + XW'(1);
                        rd_y <= cur_y;
                    end
                end
            end
            if (push) begin
                fifo_q[wp] <= ent_in;
                wp <= ~wp;
            end
            if (pop) rp <= ~rp;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
            if (start_go) begin
                max_val  <= '0;
                max_addr <= '0;
            end else if (pop && (head.data > max_val)) begin
                max_val  <= head.data;
                max_addr <= head_addr;
            end
        end
    end

`ifdef DT_STREAM_THRESH_EN
    assign out_bin = head.bin;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bin_count <= '0;
        end else if (start_go) begin
            bin_count <= '0;
        end else if (pop && head.bin) begin
            bin_count <= bin_count + (ADDR_W+1)'(1);
        end
    end
`endif

    assign out_data  = head.data;
    assign out_x     = head.x;
    assign out_y     = head.y;
    assign out_last  = head.last;
    assign busy      = (state == SCAN) || (state == DRAIN);
    assign scan_done = (state == DONE);

endmodule

// File: tb/tb_dt_map_streamer.sv
// tb_dt_map_streamer: directed scenarios for dt_map_streamer
// against a 128x128 behavioural result RAM.
module tb_dt_map_streamer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        res_rd;
    logic [13:0] res_addr;
    logic [7:0]  res_di;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [6:0]  out_x;
    logic [6:0]  out_y;
    logic        out_last;
    logic        busy;
    logic        scan_done;
    logic [7:0]  max_val;
    logic [13:0] max_addr;
`ifdef DT_STREAM_THRESH_EN
    logic [7:0]  thr;
    logic        out_bin;
    logic [14:0] bin_count;
`endif

    logic [7:0] mem [16384];

    int n_checks = 0;
    int n_fail   = 0;

    int s_nx, s_bad, s_stab, s_last, s_cyc, s_first;
    bit s_fin;

    dt_map_streamer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .res_rd    (res_rd),
        .res_addr  (res_addr),
        .res_di    (res_di),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_last  (out_last),
`ifdef DT_STREAM_THRESH_EN
        .thr       (thr),
        .out_bin   (out_bin),
        .bin_count (bin_count),
`endif
        .busy      (busy),
        .scan_done (scan_done),
        .max_val   (max_val),
        .max_addr  (max_addr)
    );

    // RAM latches the address in the DUT's res_addr register
    assign res_di = mem[res_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load_ramp();
        for (int a = 0; a < 16384; a++) mem[a] = 8'(a);
    endtask

    task automatic load_zero();
        for (int a = 0; a < 16384; a++) mem[a] = 8'd0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Consumer: drives out_ready and tallies deviations from
    // the row-major sequence held in mem.
    task automatic stream(input int low_pct, input int stop_n);
        bit         pend;
        bit         rdy;
        bit         bad;
        logic [7:0] pd;
        logic [6:0] px, py;
        logic       pl;
        pend = 1'b0;
        pd = '0; px = '0; py = '0; pl = 1'b0;
        s_nx = 0; s_bad = 0; s_stab = 0; s_last = 0;
        s_cyc = 0; s_fin = 1'b0; s_first = -1;
        while (s_cyc < 40000) begin
            @(negedge clk);
            s_cyc++;
            if (scan_done) begin
                s_fin = 1'b1;
                break;
            end
            rdy = ($urandom_range(0, 99) >= low_pct);
            out_ready = rdy;
            if (pend && (!out_valid || out_data !== pd ||
                         out_x !== px || out_y !== py ||
                         out_last !== pl))
                s_stab++;
            if (out_valid && rdy) begin
                bad = (s_nx > 16383) ||
                      (out_data !== mem[s_nx]) ||
                      (out_x !== 7'(s_nx % 128)) ||
                      (out_y !== 7'(s_nx / 128)) ||
                      (out_last !== (s_nx == 16383));
`ifdef DT_STREAM_THRESH_EN
                if (s_nx <= 16383 &&
                    out_bin !== (mem[s_nx] >= thr))
                    bad = 1'b1;
`endif
                if (bad) begin
                    s_bad++;
                    if (s_first < 0) s_first = s_nx;
                end
                if (out_last) s_last++;
                s_nx++;
                if (s_nx == stop_n) break;
            end
            pend = out_valid && !rdy;
            pd = out_data; px = out_x;
            py = out_y;    pl = out_last;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({res_rd, res_addr, out_valid, out_data, out_x,
             out_y, out_last, busy, scan_done, max_val,
             max_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got nonzero outputs, want 0");
        end
`ifdef DT_STREAM_THRESH_EN
        n_checks++;
        if (bin_count !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_bin_count: got %0d, want 0",
                     bin_count);
        end
`endif
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({res_rd, busy, out_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_quiet: got rd/busy/valid=%b, want 000",
                     {res_rd, busy, out_valid});
        end
    endtask

    task automatic test_stream_ramp();
        load_ramp();
`ifdef DT_STREAM_THRESH_EN
        thr = 8'd200;
`endif
        out_ready = 1'b1;
        pulse_start();
        stream(0, -1);
        n_checks++;
        if (!s_fin) begin
            n_fail++;
            $display("FAIL ramp_timeout: got done=0 after %0d, want 1",
                     s_cyc);
        end
        n_checks++;
        if (s_nx !== 16384) begin
            n_fail++;
            $display("FAIL ramp_count: got %0d, want 16384", s_nx);
        end
        n_checks++;
        if (s_bad !== 0) begin
            n_fail++;
            $display("FAIL ramp_seq: got %0d bad (first %0d), want 0",
                     s_bad, s_first);
        end
        n_checks++;
        if (s_last !== 1) begin
            n_fail++;
            $display("FAIL ramp_last: got %0d, want 1", s_last);
        end
        n_checks++;
        if (s_cyc + 1 > 16387) begin
            n_fail++;
            $display("FAIL ramp_latency: got %0d cycles, want <=16387",
                     s_cyc + 1);
        end
        n_checks++;
        if (max_val !== 8'd255 || max_addr !== 14'd255) begin
            n_fail++;
            $display("FAIL ramp_max: got %0d@%0d, want 255@255",
                     max_val, max_addr);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ramp_busy: got %b, want 0", busy);
        end
`ifdef DT_STREAM_THRESH_EN
        n_checks++;
        if (bin_count !== 15'd3584) begin
            n_fail++;
            $display("FAIL ramp_bin_count: got %0d, want 3584",
                     bin_count);
        end
`endif
    endtask

    task automatic test_ready_toggle();
`ifdef DT_STREAM_THRESH_EN
        thr = 8'd0;
`endif
        out_ready = 1'b1;
        pulse_start();
        stream(30, -1);
        n_checks++;
        if (!s_fin || s_nx !== 16384) begin
            n_fail++;
            $display("FAIL tog_count: got %0d (done=%b), want 16384",
                     s_nx, s_fin);
        end
        n_checks++;
        if (s_bad !== 0) begin
            n_fail++;
            $display("FAIL tog_seq: got %0d bad (first %0d), want 0",
                     s_bad, s_first);
        end
        n_checks++;
        if (s_stab !== 0) begin
            n_fail++;
            $display("FAIL tog_stable: got %0d changes, want 0",
                     s_stab);
        end
        n_checks++;
        if (max_val !== 8'd255 || max_addr !== 14'd255) begin
            n_fail++;
            $display("FAIL tog_max: got %0d@%0d, want 255@255",
                     max_val, max_addr);
        end
`ifdef DT_STREAM_THRESH_EN
        n_checks++;
        if (bin_count !== 15'd16384) begin
            n_fail++;
            $display("FAIL tog_bin_count: got %0d, want 16384",
                     bin_count);
        end
`endif
    endtask

    task automatic test_restart_from_done();
        int nrd;
        load_zero();
        mem[5000] = 8'd9;
        mem[9000] = 8'd9;
        n_checks++;
        if (scan_done !== 1'b1) begin
            n_fail++;
            $display("FAIL rs_in_done: got %b, want 1", scan_done);
        end
        out_ready = 1'b0;
        pulse_start();
        nrd = 0;
        for (int i = 0; i < 10; i++) begin
            if (res_rd) nrd++;
            if (i == 0) begin
                n_checks++;
                if ({scan_done, busy} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL rs_clear: got done/busy=%b, want 01",
                             {scan_done, busy});
                end
            end
            if (i < 9) @(negedge clk);
        end
        n_checks++;
        if (nrd !== 2) begin
            n_fail++;
            $display("FAIL rs_reads: got %0d, want 2", nrd);
        end
        n_checks++;
        if ({out_valid, out_data, out_x, out_y} !== 23'h400000) begin
            n_fail++;
            $display("FAIL rs_head: got v=%b d=%0d x=%0d y=%0d, want 1 0 0 0",
                     out_valid, out_data, out_x, out_y);
        end
        stream(0, -1);
        n_checks++;
        if (!s_fin || s_nx !== 16384 || s_bad !== 0) begin
            n_fail++;
            $display("FAIL rs_seq: got n=%0d bad=%0d, want 16384 0",
                     s_nx, s_bad);
        end
        n_checks++;
        if (max_val !== 8'd9 || max_addr !== 14'd5000) begin
            n_fail++;
            $display("FAIL rs_tie_max: got %0d@%0d, want 9@5000",
                     max_val, max_addr);
        end
    endtask

    task automatic test_reset_midscan();
        load_ramp();
        out_ready = 1'b1;
        pulse_start();
        stream(0, 700);
        n_checks++;
        if (s_nx !== 700) begin
            n_fail++;
            $display("FAIL mid_reach: got %0d, want 700", s_nx);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({res_rd, res_addr, out_valid, out_data, out_x,
             out_y, out_last, busy, scan_done, max_val,
             max_addr} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_now: got nonzero outputs, want 0");
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({res_rd, res_addr, out_valid, busy,
             max_val, max_addr} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_held: got nonzero outputs, want 0");
        end
        load_zero();
        mem[16383] = 8'd77;
        reset = 1'b1;
        @(negedge clk);
        pulse_start();
        stream(0, -1);
        n_checks++;
        if (!s_fin || s_nx !== 16384 || s_bad !== 0) begin
            n_fail++;
            $display("FAIL mid_seq: got n=%0d bad=%0d first=%0d, want 16384 0",
                     s_nx, s_bad, s_first);
        end
        n_checks++;
        if (max_val !== 8'd77 || max_addr !== 14'd16383) begin
            n_fail++;
            $display("FAIL mid_max: got %0d@%0d, want 77@16383",
                     max_val, max_addr);
        end
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
`ifdef DT_STREAM_THRESH_EN
        thr       = 8'd0;
`endif
        load_zero();
        test_reset();
        test_stream_ramp();
        test_ready_toggle();
        test_restart_from_done();
        test_reset_midscan();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dt_map_streamer.md
Name: dt_map_streamer

Overview:
- Downstream stage of the distance-transform engine.
- After the engine finishes, this block scans the 128x128 8-bit result RAM in row-major order and streams every pixel out over a valid/ready interface.
- Each output pixel carries its coordinates and a last-pixel flag.
- While streaming, it tracks the maximum distance value and where it occurs. Both results feed the downstream feature/report logic.

Parameters:
- IMG_W, 128, image width in pixels (columns, x)
- IMG_H, 128, image height in pixels (rows, y)
- ADDR_W, 14, result RAM address width; IMG_W*IMG_H must be <= 2^ADDR_W
- DATA_W, 8, distance value width

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  begin scan; sampled only in IDLE or DONE
- res_rd  output  1  result RAM read strobe
- res_addr  output  ADDR_W  result RAM read address, equal to y*IMG_W + x
- res_di  input  DATA_W  result RAM read data
- out_valid  output  1  out_* fields hold a valid pixel
- out_ready  input  1  consumer accepts the pixel this cycle
- out_data  output  DATA_W  distance value
- out_x  output  7  column of the pixel
- out_y  output  7  row of the pixel
- out_last  output  1  pixel is (IMG_W-1, IMG_H-1)
- busy  output  1  high from start until the last pixel is accepted
- scan_done  output  1  held high in DONE
- max_val  output  DATA_W  largest accepted value in the current scan
- max_addr  output  ADDR_W  address of the first occurrence of max_val

Behaviour:
- Reset values: res_rd=0, res_addr=0, out_valid=0, out_data=0, out_x=0, out_y=0, out_last=0, busy=0, scan_done=0, max_val=0, max_addr=0. FIFO is empty, read counter is 0.
- RAM timing: when res_rd=1 with res_addr registered in cycle N, res_di is valid during cycle N+1 and is captured at the end of N+1. Reads are one cycle and pipelined; one new read may be issued per cycle.
- Buffering: 2-entry output FIFO holding {data, x, y, last}.
  - A read is issued only when (FIFO occupancy + reads in flight) < 2, so data is never dropped.
  - The FIFO head drives the out_* fields.
- Handshake: a transfer happens when out_valid && out_ready.
  - While out_valid=1, out_* must stay stable until the transfer.
  - out_ready=1 every cycle gives one pixel per cycle after the initial 2-cycle latency (start sampled -> first out_valid).
- FSM states: IDLE, SCAN, DRAIN, DONE.
  - IDLE: start=1 -> SCAN. On entry, clear max_val and max_addr to 0, set read address to 0, and set busy=1.
  - SCAN: issue reads per the credit rule; the address increments after each issued read. After the read of address IMG_W*IMG_H-1 is issued -> DRAIN.
  - DRAIN: no new reads. When the pixel with out_last=1 is transferred -> DONE, with busy=0 and scan_done=1.
  - DONE: scan_done stays high; max_val and max_addr hold. start=1 -> SCAN, with the same entry actions as from IDLE, and scan_done clears.
- Coordinates: x wraps from IMG_W-1 to 0 and increments y. out_last is set only for the final address. No wrap occurs past the final pixel.
- Max tracking: updated on each transfer. If out_data > max_val (strict), then max_val <= out_data and max_addr <= y*IMG_W + x. Ties keep the earlier address. An all-zero map gives max_val=0 and max_addr=0.
- res_rd is low whenever no read is issued. res_addr holds its last value when idle.
- start while in SCAN or DRAIN is ignored.
- Reset assertion mid-scan returns every register to its reset value immediately. Any data in flight is discarded.

Optional Feature:
- Macro: DT_STREAM_THRESH_EN.
- When defined:
  - Adds input thr (DATA_W) and output out_bin (1).
  - out_bin = (out_data >= thr). It is computed when the entry is written into the FIFO, using thr sampled on that cycle, and travels with the entry.
  - Adds output bin_count (ADDR_W+1): number of transferred pixels with out_bin=1. Cleared on scan start.
- When not defined: none of these ports or registers exist, and the remaining behaviour is identical.

Test Plan:
- RAM preloaded with res[a] = a[7:0]; out_ready held at 1; pulse start. Required:
  - 16384 transfers in order, out_data = a[7:0], with correct out_x/out_y.
  - out_last only on the final pixel.
  - max_val=255, max_addr=255.
  - scan_done rises after the last transfer.
  - Total time from start to scan_done = 16384+3 cycles or less.
- Same map; out_ready toggled pseudo-randomly with 30% low. Required: identical transfer sequence, no duplicated or skipped pixels, and out_* stable while valid && !ready.
- Map all zero except res[5000]=9 and res[9000]=9. Required: max_val=9, max_addr=5000 (first occurrence wins).
- Reset asserted at transfer 700, then released and started again on a map with res[16383]=77 as the only nonzero value. Required: all outputs are at reset values during reset; the new scan begins at (0,0); max_val=77, max_addr=16383.
- In DONE, start pulsed again with out_ready=0 for 10 cycles. Required: scan_done clears, the FIFO fills to 2 entries, res_rd stops after 2 issued reads, and streaming resumes correctly when out_ready=1.
- With DT_STREAM_THRESH_EN defined: res[a]=a[7:0] and thr=200. Required: out_bin=1 exactly for pixels with value >= 200, and bin_count = 64*56 = 3584.
